// File: rtl/student_fir_scheduler_pkg.sv
// Shared definitions for the FIR scheduler: default parameter values and
// the scheduler FSM state encoding.
package student_fir_scheduler_pkg;

  localparam int unsigned DEF_DATA_SIZE         = 16;
  localparam int unsigned DEF_DATA_SIZE_FIR_OUT = 24;
  localparam int unsigned DEF_FIFO_DEPTH        = 4;
  localparam int unsigned DEF_ADDER_LAT         = 1;
  localparam int unsigned DEF_TIMEOUT           = 1024;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_BUSY,
    ST_DRAIN,
    ST_OUT
  } state_t;

endpackage

// File: rtl/student_fir_sched_fifo.sv
// Sample queue for the FIR scheduler. Power-of-two depth, first-word
// fall-through head (dout is the oldest entry whenever empty is low).
// Ports:
//   clk_i, rst_i  clock, synchronous active-high reset (empties the queue)
//   push, din     write din at the tail; caller only pushes when !full or popping
//   pop           drop the head; caller only pops when !empty
//   dout          current head entry
//   full, empty   occupancy flags
module student_fir_sched_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  // One extra pointer bit distinguishes full from empty when indices match.
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/student_fir_scheduler.sv
// FIR scheduler: queues audio-stream and host-injected samples, issues them
// one at a time to an external FIR array, waits for completion plus the
// adder-tree latency, and registers the summed result.
// Ports:
//   clk_i, rst_i                      clock, synchronous active-high reset
//   stream_valid_i, stream_sample_i   audio strobe (rising edge = new sample)
//   host_valid_i, host_sample_i       host request, held until host_ready_o
//   host_ready_o                      host sample accepted this cycle
//   fir_start_o, fir_sample_o         one-cycle start pulse and held sample
//   fir_done_i, fir_y_i               FIR completion pulse and summed result
//   y_valid_o, y_o                    result strobe and held result
//   busy_o                            FSM not in IDLE
//   timeout_o, clr_i                  sticky abort flag and its clear
// Build option FIR_SCHED_STATS_EN adds drop_cnt_o / issue_cnt_o, saturating
// 16-bit counters of dropped stream samples and issued starts.
module student_fir_scheduler
  import student_fir_scheduler_pkg::*;
#(
  parameter int unsigned DATA_SIZE         = DEF_DATA_SIZE,
  parameter int unsigned DATA_SIZE_FIR_OUT = DEF_DATA_SIZE_FIR_OUT,
  parameter int unsigned FIFO_DEPTH        = DEF_FIFO_DEPTH,
  parameter int unsigned ADDER_LAT         = DEF_ADDER_LAT,
  parameter int unsigned TIMEOUT           = DEF_TIMEOUT
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         stream_valid_i,
  input  logic [DATA_SIZE-1:0]         stream_sample_i,
  input  logic                         host_valid_i,
  input  logic [DATA_SIZE-1:0]         host_sample_i,
  output logic                         host_ready_o,
  output logic                         fir_start_o,
  output logic [DATA_SIZE-1:0]         fir_sample_o,
  input  logic                         fir_done_i,
  input  logic [DATA_SIZE_FIR_OUT-1:0] fir_y_i,
  output logic                         y_valid_o,
  output logic [DATA_SIZE_FIR_OUT-1:0] y_o,
  output logic                         busy_o,
  input  logic                         clr_i,
  output logic                         timeout_o
`ifdef FIR_SCHED_STATS_EN
  ,
  output logic [15:0]                  drop_cnt_o,
  output logic [15:0]                  issue_cnt_o
`endif
);

  localparam int unsigned TW       = $clog2(TIMEOUT + 1);
  localparam int unsigned LW       = $clog2(ADDER_LAT + 2);
  localparam int unsigned LAT_LAST = (ADDER_LAT > 0) ? ADDER_LAT - 1 : 0;

  state_t               state, next;
  logic                 stream_prev;
  logic                 stream_edge;
  logic                 fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [DATA_SIZE-1:0] fifo_din, fifo_head;
  logic [TW-1:0]        busy_cnt;
  logic [LW-1:0]        lat_cnt;
  logic                 timeout_evt;

  assign stream_edge = stream_valid_i & ~stream_prev;
  assign fifo_pop    = (state == ST_ISSUE);
  // A full queue still takes a stream sample when the head leaves this cycle.
  assign host_ready_o = host_valid_i & ~fifo_full & ~stream_edge & ~rst_i;
  assign fifo_push    = (stream_edge & (~fifo_full | fifo_pop)) | host_ready_o;
  assign fifo_din     = stream_edge ? stream_sample_i : host_sample_i;
  assign busy_o       = (state != ST_IDLE);

  student_fir_sched_fifo #(
    .WIDTH (DATA_SIZE),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (fifo_push),
    .din   (fifo_din),
    .pop   (fifo_pop),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    next        = state;
    timeout_evt = 1'b0;
    unique case (state)
      ST_IDLE:  if (!fifo_empty) next = ST_ISSUE;
      ST_ISSUE: next = ST_BUSY;
      ST_BUSY: begin
        if (fir_done_i) begin
          next = (ADDER_LAT == 0) ? ST_OUT : ST_DRAIN;
        end else if (busy_cnt == TW'(TIMEOUT - 1)) begin
          timeout_evt = 1'b1;
          next        = ST_IDLE;
        end
      end
      ST_DRAIN: if (lat_cnt == LW'(LAT_LAST)) next = ST_OUT;
      ST_OUT:   next = ST_IDLE;
      default:  next = ST_IDLE;
    endcase
  end

  // Start/result outputs are loaded on the transition into ISSUE/OUT so the
  // pulses coincide with those states and y_valid_o lands ADDER_LAT+1 cycles
  // after fir_done_i.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= ST_IDLE;
      stream_prev  <= 1'b0;
      fir_start_o  <= 1'b0;
      fir_sample_o <= '0;
      y_valid_o    <= 1'b0;
      y_o          <= '0;
      busy_cnt     <= '0;
      lat_cnt      <= '0;
      timeout_o    <= 1'b0;
    end else begin
      state       <= next;
      stream_prev <= stream_valid_i;
      fir_start_o <= (next == ST_ISSUE);
      if (next == ST_ISSUE) fir_sample_o <= fifo_head;
      y_valid_o <= (next == ST_OUT);
      if (next == ST_OUT) y_o <= fir_y_i;
      busy_cnt <= (state == ST_BUSY)  ? busy_cnt + 1'b1 : '0;
      lat_cnt  <= (state == ST_DRAIN) ? lat_cnt + 1'b1  : '0;
      if (timeout_evt)  timeout_o <= 1'b1;
      else if (clr_i)   timeout_o <= 1'b0;
    end
  end

`ifdef FIR_SCHED_STATS_EN
  logic drop;
  assign drop = stream_edge & fifo_full & ~fifo_pop;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      drop_cnt_o  <= '0;
      issue_cnt_o <= '0;
    end else begin
      if (drop && drop_cnt_o != '1) drop_cnt_o <= drop_cnt_o + 1'b1;
      if (next == ST_ISSUE && issue_cnt_o != '1) issue_cnt_o <= issue_cnt_o + 1'b1;
    end
  end
`endif

endmodule
